// File: rtl/vmul_pkg.sv
// vmul_pkg: shared constants for the vector integer multiplier.
//   - SEW encodings of in_sew (element width 8/16/32/64).
//   - opSel encodings of in_opSel (low half, or signed/unsigned/mixed high half).
//   - VMUL_LAT: clock edges from acceptance until the result is visible on out_*
//     when the output FIFO is empty.
package vmul_pkg;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b10;
  localparam logic [1:0] OP_MULHSU = 2'b11;

  localparam int VMUL_LAT = 3;
  localparam int LANE_W   = 64;

endpackage

// File: rtl/vmul_lane.sv
// vmul_lane: one 64-bit slice of the element-wise multiplier.
//   Stage 1 registers the lane operands; stage 2 registers the per-element
//   products for the SEW seen in stage 1; the stage-3 result selection is
//   combinational on res_o and is captured by the FIFO in the top level.
// Ports:
//   clk            clock
//   a_i, b_i       64-bit lane slices of vs2 / vs1 (captured every cycle)
//   sew1_i, op1_i  SEW and opSel of the beat currently in stage 1
//   sew2_i, op2_i  SEW and opSel of the beat currently in stage 2
//   res_o          64-bit lane result for the beat in stage 2
// Configuration macro VMUL_MULH_EN: when defined, products are full 2*SEW-bit
// and signedness-aware so the high half can be returned; when undefined only
// the low SEW bits of each product are built and opSel is ignored.
module vmul_lane
  import vmul_pkg::*;
(
  input  logic        clk,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [1:0]  sew1_i,
  input  logic [1:0]  op1_i,
  input  logic [1:0]  sew2_i,
  input  logic [1:0]  op2_i,
  output logic [63:0] res_o
);

  logic [63:0] a_d, a_q;
  logic [63:0] b_d, b_q;

  always_comb begin
    a_d = a_i;
    b_d = b_i;
  end

  // Operand registers carry no reset: their contents only matter while the
  // top level's stage valid bits say so.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

`ifdef VMUL_MULH_EN

  // Operand signedness only affects the high half; for OP_MUL the low half
  // is identical whichever extension is used.
  logic a_sgn;
  logic b_sgn;
  assign a_sgn = (op1_i == OP_MULH) || (op1_i == OP_MULHSU);
  assign b_sgn = (op1_i == OP_MULH);

  // p_all[s] holds every element product for SEW index s, element i at
  // bits [2W*i +: 2W].
  logic [3:0][127:0] p_all;
  logic [127:0]      prod_d, prod_q;
  logic [3:0][63:0]  r_all;
  logic              hi_sel;

  for (genvar si = 0; si < 4; si++) begin : g_sew
    localparam int W = 8 << si;
    localparam int N = LANE_W / W;
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      logic [2*W-1:0] xa;
      logic [2*W-1:0] xb;
      // Extending both operands to 2W bits and keeping the low 2W bits of the
      // product gives the exact signed/unsigned 2W-bit product.
      assign xa = {{W{a_sgn & a_q[W*gi+W-1]}}, a_q[W*gi +: W]};
      assign xb = {{W{b_sgn & b_q[W*gi+W-1]}}, b_q[W*gi +: W]};
      assign p_all[si][2*W*gi +: 2*W] = xa * xb;
      assign r_all[si][W*gi +: W] = hi_sel ? prod_q[2*W*gi+W +: W]
                                           : prod_q[2*W*gi +: W];
    end
  end

  assign hi_sel = (op2_i != OP_MUL);

  always_comb begin
    prod_d = p_all[sew1_i];
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign res_o = r_all[sew2_i];

`else

  // Low-half only: each element product is truncated to SEW bits, so the
  // stage-2 register already holds the final lane result.
  logic [3:0][63:0] lo_all;
  logic [63:0]      prod_d, prod_q;

  for (genvar si = 0; si < 4; si++) begin : g_sew
    localparam int W = 8 << si;
    localparam int N = LANE_W / W;
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      assign lo_all[si][W*gi +: W] = a_q[W*gi +: W] * b_q[W*gi +: W];
    end
  end

  always_comb begin
    prod_d = lo_all[sew1_i];
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign res_o = prod_q;

  logic unused_ctrl;
  assign unused_ctrl = ^{op1_i, sew2_i, op2_i};

`endif

endmodule

// File: rtl/vmul_pipe.sv
// vmul_pipe: backpressure-aware element-wise vector integer multiplier.
//   Three-stage pipeline (operand capture, product, select) feeding a
//   credit-controlled output FIFO. A beat is only accepted when the FIFO
//   entries plus the beats already in flight leave room for it, so the
//   pipeline never stalls and the FIFO can never overflow.
// Parameters: DATA_WIDTH (multiple of 64), ADDR_WIDTH (tag), FIFO_DEPTH (>= 2).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_vec0, in_vec1                 operands vs2 / vs1
//   in_valid, in_ready               input handshake
//   in_sew, in_opSel, in_addr        element width, operation, tag
//   out_vec, out_addr                head-of-FIFO result and tag (0 when empty)
//   out_valid, out_ready             output handshake
// Configuration macro VMUL_MULH_EN: enables the high-half operations; when
// undefined every opSel returns the low-half product (see vmul_lane).
module vmul_pipe
  import vmul_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            in_opSel,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int LANES    = DATA_WIDTH / LANE_W;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W    = CNT_W + 1;
  localparam int ENTRY_W  = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  // Control state (reset)
  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;

  // Side-band pipeline (no reset)
  logic [ADDR_WIDTH-1:0] s1_addr_d, s1_addr_q;
  logic [ADDR_WIDTH-1:0] s2_addr_d, s2_addr_q;
  logic [1:0]            s1_sew_d, s1_sew_q;
  logic [1:0]            s2_sew_d, s2_sew_q;
  logic [1:0]            s1_op_d, s1_op_q;
  logic [1:0]            s2_op_d, s2_op_q;

  logic [DATA_WIDTH-1:0] lane_res;
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [SUM_W-1:0]      in_flight;
  logic                  accept;
  logic                  push;
  logic                  pop;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    vmul_lane u_lane (
      .clk    (clk),
      .a_i    (in_vec0[LANE_W*gi +: LANE_W]),
      .b_i    (in_vec1[LANE_W*gi +: LANE_W]),
      .sew1_i (s1_sew_q),
      .op1_i  (s1_op_q),
      .sew2_i (s2_sew_q),
      .op2_i  (s2_op_q),
      .res_o  (lane_res[LANE_W*gi +: LANE_W])
    );
  end

  // Credit is taken from registered state only; a pop this cycle frees its
  // slot for acceptance one cycle later, which keeps out_ready off the
  // in_ready path.
  assign in_flight = SUM_W'(count_q) + SUM_W'(s1_valid_q) + SUM_W'(s2_valid_q);
  assign in_ready  = !rst && (in_flight < SUM_W'(FIFO_DEPTH));

  assign out_valid = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign out_vec   = out_valid ? head[ENTRY_W-1 -: DATA_WIDTH] : '0;
  assign out_addr  = out_valid ? head[ADDR_WIDTH-1:0] : '0;

  always_comb begin
    accept     = in_valid & in_ready;
    push       = s2_valid_q;
    pop        = out_valid & out_ready;

    s1_valid_d = accept;
    s2_valid_d = s1_valid_q;

    s1_addr_d  = in_addr;
    s1_sew_d   = in_sew;
    s1_op_d    = in_opSel;
    s2_addr_d  = s1_addr_q;
    s2_sew_d   = s1_sew_q;
    s2_op_d    = s1_op_q;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr_q <= s1_addr_d;
    s1_sew_q  <= s1_sew_d;
    s1_op_q   <= s1_op_d;
    s2_addr_q <= s2_addr_d;
    s2_sew_q  <= s2_sew_d;
    s2_op_q   <= s2_op_d;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {lane_res, s2_addr_q};
    end
  end

endmodule

// File: tb/tb_vmul_pipe.sv
// tb_vmul_pipe: self-checking bench for vmul_pipe (DATA_WIDTH=128,
// ADDR_WIDTH=32, FIFO_DEPTH=4). A table of hand-computed vectors checks
// values, tags and latency; a scoreboard fed by an arithmetic reference model
// checks every beat that leaves the DUT. Honours VMUL_MULH_EN like the RTL.
module tb_vmul_pipe;
  import vmul_pkg::*;

  logic         clk;
  logic         rst;
  logic [127:0] in_vec0;
  logic [127:0] in_vec1;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sew;
  logic [1:0]   in_opSel;
  logic [31:0]  in_addr;
  logic [127:0] out_vec;
  logic [31:0]  out_addr;
  logic         out_valid;
  logic         out_ready;

  vmul_pipe #(.DATA_WIDTH(128), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec0   (in_vec0),
    .in_vec1   (in_vec1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sew    (in_sew),
    .in_opSel  (in_opSel),
    .in_addr   (in_addr),
    .out_vec   (out_vec),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference model: element-wise integer product from plain arithmetic.
  function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b,
                                           input logic [1:0] sew, input logic [1:0] op);
    int               s;
    bit               hi, sa, sb;
    logic [127:0]     r;
    logic [63:0]      ea, eb, mask;
    logic signed [131:0] va, vb, p;
    s  = 8 << sew;
    hi = 1'b0; sa = 1'b0; sb = 1'b0;
`ifdef VMUL_MULH_EN
    hi = (op != 2'b00);
    sa = (op == 2'b01) || (op == 2'b11);
    sb = (op == 2'b01);
`else
    if (op == 2'b11) hi = 1'b0;
`endif
    r = '0;
    mask = 64'((65'd1 << s) - 65'd1);
    for (int i = 0; i < 128 / s; i++) begin
      ea = 64'(a >> (s * i)) & mask;
      eb = 64'(b >> (s * i)) & mask;
      va = $signed({68'd0, ea});
      vb = $signed({68'd0, eb});
      if (sa && ea[s-1]) va = va - (132'sd1 <<< s);
      if (sb && eb[s-1]) vb = vb - (132'sd1 <<< s);
      p = va * vb;
      if (hi) p = p >>> s;
      r = r | (128'(p[63:0] & mask) << (s * i));
    end
    return r;
  endfunction

  // Scoreboard: record accepted beats, compare every beat taken at the output.
  typedef struct {
    logic [127:0] vec;
    logic [31:0]  addr;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got tag %h, required no output", out_addr);
        end else begin
          e = exp_q.pop_front();
          $display("out tag=%h vec=%h", out_addr, out_vec);
          check("sb_vec", out_vec, e.vec);
          check("sb_tag", {96'd0, out_addr}, {96'd0, e.addr});
          n_pops++;
        end
      end
      if (in_valid && in_ready) begin
        e.vec  = ref_mul(in_vec0, in_vec1, in_sew, in_opSel);
        e.addr = in_addr;
        exp_q.push_back(e);
        n_acc++;
      end
    end
  end

  // Directed vectors (expected values computed by hand).
`ifdef VMUL_MULH_EN
  localparam logic [127:0] E_H8    = {16{8'h40}};
  localparam logic [127:0] E_HU8   = {16{8'hFE}};
  localparam logic [127:0] E_H32   = '0;
  localparam logic [127:0] E_HU32  = {4{32'hFFFF_FFFE}};
  localparam logic [127:0] E_HSU16 = {8{16'hFFFF}};
  localparam logic [127:0] E_HU64  = {2{64'h2}};
`else
  localparam logic [127:0] E_H8    = '0;
  localparam logic [127:0] E_HU8   = {16{8'h01}};
  localparam logic [127:0] E_H32   = {4{32'h1}};
  localparam logic [127:0] E_HU32  = {4{32'h1}};
  localparam logic [127:0] E_HSU16 = {8{16'h0001}};
  localparam logic [127:0] E_HU64  = '0;
`endif

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [1:0]   sew;
    logic [1:0]   op;
    logic [31:0]  addr;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic run_vec(input logic [127:0] a, input logic [127:0] b, input logic [1:0] sew,
                         input logic [1:0] op, input logic [31:0] addr, input logic [127:0] exp,
                         input string tag);
    int guard;
    int lat;
    in_vec0 = a; in_vec1 = b; in_sew = sew; in_opSel = op; in_addr = addr;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) check({tag, "_in_ready_wait"}, {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(VMUL_LAT - 1));
    check({tag, "_vec"}, out_vec, exp);
    check({tag, "_tag"}, {96'd0, out_addr}, {96'd0, addr});
    $display("vec %s sew=%0d op=%0d tag=%h -> %h", tag, sew, op, out_addr, out_vec);
    @(posedge clk); #1;
  endtask

  int acc0, pop0, stalls, bubbles, g, seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_vec0 = '0; in_vec1 = '0; in_sew = '0; in_opSel = '0; in_addr = '0;

    tbl[0] = '{a: {16{8'h7F}}, b: {16{8'h02}}, sew: SEW_8,  op: OP_MUL,    addr: 32'hA000_0001, exp: {16{8'hFE}}};
    tbl[1] = '{a: {4{32'hFFFF_FFFF}}, b: {4{32'hFFFF_FFFF}}, sew: SEW_32, op: OP_MULH,   addr: 32'hA000_0002, exp: E_H32};
    tbl[2] = '{a: {4{32'hFFFF_FFFF}}, b: {4{32'hFFFF_FFFF}}, sew: SEW_32, op: OP_MULHU,  addr: 32'hA000_0003, exp: E_HU32};
    tbl[3] = '{a: {4{32'hFFFF_FFFF}}, b: {4{32'hFFFF_FFFF}}, sew: SEW_32, op: OP_MUL,    addr: 32'hA000_0004, exp: {4{32'h1}}};
    tbl[4] = '{a: {8{16'hFFFF}}, b: {8{16'hFFFF}}, sew: SEW_16, op: OP_MULHSU, addr: 32'hA000_0005, exp: E_HSU16};
    tbl[5] = '{a: {2{64'h8000_0000_0000_0000}}, b: {2{64'd4}}, sew: SEW_64, op: OP_MULHU, addr: 32'hA000_0006, exp: E_HU64};
    tbl[6] = '{a: {16{8'h80}}, b: {16{8'h80}}, sew: SEW_8,  op: OP_MULH,   addr: 32'hA000_0007, exp: E_H8};
    tbl[7] = '{a: {16{8'hFF}}, b: {16{8'hFF}}, sew: SEW_8,  op: OP_MULHU,  addr: 32'hA000_0008, exp: E_HU8};
    tbl[8] = '{a: {8{16'h1234}}, b: {8{16'h0010}}, sew: SEW_16, op: OP_MUL, addr: 32'hA000_0009, exp: {8{16'h2340}}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_vec", out_vec, 128'd0);
    check("rst_out_addr", {96'd0, out_addr}, 128'd0);
    check("rst_in_ready_after", {127'd0, in_ready}, 128'd1);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i].a, tbl[i].b, tbl[i].sew, tbl[i].op, tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Backpressure: consumer stalled, producer always offering
    out_ready = 1'b0;
    acc0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_vec0 = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_vec1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_sew = 2'($urandom()); in_opSel = 2'($urandom());
      in_addr = 32'h7000 + 32'(n_acc - acc0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 128'(n_acc - acc0), 128'd4);
    check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    check("bp_out_valid", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_path", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", {127'd0, in_ready}, 128'd1);
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin @(posedge clk); #1; g++; end
    check("bp_drained", 128'(exp_q.size()), 128'd0);

    // Streaming: 32 back-to-back beats, consumer always ready
    stalls = 0; bubbles = 0; acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          in_vec0 = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_vec1 = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_sew = 2'($urandom()); in_opSel = 2'($urandom());
          in_addr = 32'h5000 + 32'(i);
          in_valid = 1'b1;
          if (!in_ready) stalls++;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        g = 0;
        while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
        for (int j = 0; j < 32; j++) begin
          if (!out_valid) bubbles++;
          @(posedge clk); #1;
        end
      end
    join
    check("stream_stalls", 128'(stalls), 128'd0);
    check("stream_bubbles", 128'(bubbles), 128'd0);
    check("stream_accepted", 128'(n_acc - acc0), 128'd32);
    check("stream_drained", 128'(exp_q.size()), 128'd0);

    // Random producer / random consumer
    acc0 = n_acc; pop0 = n_pops;
    for (int i = 0; i < 300 && (n_acc - acc0) < 40; i++) begin
      in_vec0 = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_vec1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_sew = 2'($urandom()); in_opSel = 2'($urandom());
      in_addr = 32'h6000 + 32'(i);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin @(posedge clk); #1; g++; end
    check("rand_drained", 128'(exp_q.size()), 128'd0);
    check("rand_no_loss", 128'(n_pops - pop0), 128'(n_acc - acc0));

    // Reset with two beats in flight and one in the FIFO
    out_ready = 1'b0;
    in_vec0 = {4{32'h1111_1111}}; in_vec1 = {4{32'h2}}; in_sew = SEW_32; in_opSel = OP_MUL;
    in_addr = 32'h8001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_fifo", {127'd0, out_valid}, 128'd1);
    in_valid = 1'b1; in_addr = 32'h8002;
    @(posedge clk); #1;
    in_addr = 32'h8003;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_mid_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    check("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_mid_out_vec", out_vec, 128'd0);
    check("rst_mid_out_addr", {96'd0, out_addr}, 128'd0);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst_flushed", 128'(seen), 128'd0);
    run_vec({16{8'h7F}}, {16{8'h02}}, SEW_8, OP_MUL, 32'h9000_0001, {16{8'hFE}}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
